// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - control and status bundle for the programmable clock divider
interface clk_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] n_in;
    logic             mode_in;
    logic             n_load;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] clk_count;
    logic [WIDTH-1:0] n_active;
    logic             load_pending;
    logic             cfg_err;

    modport master (
        output en, n_in, mode_in, n_load,
        input  clk_out, tick, clk_count, n_active, load_pending, cfg_err
    );

    modport slave (
        input  en, n_in, mode_in, n_load,
        output clk_out, tick, clk_count, n_active, load_pending, cfg_err
    );
endinterface

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable integer clock divider, pulse or 50% duty output
module clk_div_prog #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] DEFAULT_N = WIDTH'(4)
) (
    input  logic           ref_clk,
    input  logic           reset,
    clk_div_prog_if.slave  bus
);

    logic [WIDTH-1:0] clk_count;
    logic [WIDTH-1:0] n_active;
    logic [WIDTH-1:0] n_pend;
    logic             mode_active;
    logic             mode_pend;
    logic             load_pending;
    logic             cfg_err;
    logic             tick_q;
    logic             p_hi;
    logic             n_hi;
    logic             en_q;

    logic             terminal;
    logic             apply;
    logic             load_ok;
    logic             load_bad;
    logic [WIDTH-1:0] n_next;
    logic             mode_next;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] hi_thresh;
    logic             p_hi_next;
    logic             clk_out_c;

    assign terminal = (clk_count == '0);
    assign apply    = bus.en && terminal;
    assign load_ok  = bus.n_load && (bus.n_in != '0);
    assign load_bad = bus.n_load && (bus.n_in == '0);

    // Ratio and mode only change on a terminal edge; a same-edge load beats an older pending one.
    always_comb begin
        n_next    = n_active;
        mode_next = mode_active;
        if (apply) begin
            if (load_ok) begin
                n_next    = bus.n_in;
                mode_next = bus.mode_in;
            end else if (load_pending) begin
                n_next    = n_pend;
                mode_next = mode_pend;
            end
        end
    end

    always_comb begin
        cnt_next = clk_count - WIDTH'(1);
        if (!bus.en) begin
            cnt_next = '0;
        end else if (terminal) begin
            cnt_next = n_next - WIDTH'(1);
        end
    end

    // High for the first floor(N/2) cycles: counts N-1 down to N-floor(N/2).
    assign hi_thresh = n_next - (n_next >> 1);
    assign p_hi_next = bus.en && (cnt_next >= hi_thresh);

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            clk_count    <= '0;
            n_active     <= DEFAULT_N;
            mode_active  <= 1'b0;
            n_pend       <= '0;
            mode_pend    <= 1'b0;
            load_pending <= 1'b0;
            cfg_err      <= 1'b0;
            tick_q       <= 1'b0;
            p_hi         <= 1'b0;
        end else begin
            clk_count   <= cnt_next;
            n_active    <= n_next;
            mode_active <= mode_next;
            tick_q      <= apply;
            p_hi        <= p_hi_next;
            if (apply) begin
                load_pending <= 1'b0;
            end
            if (load_ok && !apply) begin
                n_pend       <= bus.n_in;
                mode_pend    <= bus.mode_in;
                load_pending <= 1'b1;
            end
            if (load_ok) begin
                cfg_err <= 1'b0;
            end else if (load_bad) begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Falling-edge copies: half-cycle extension for odd 50% ratios, and gating for N=1.
    always_ff @(negedge ref_clk or posedge reset) begin
        if (reset) begin
            n_hi <= 1'b0;
            en_q <= 1'b0;
        end else begin
            n_hi <= p_hi;
            en_q <= bus.en;
        end
    end

    always_comb begin
        clk_out_c = tick_q;
        if (n_active == WIDTH'(1)) begin
            clk_out_c = ref_clk & en_q;
        end else if (mode_active) begin
            clk_out_c = n_active[0] ? (p_hi | n_hi) : p_hi;
        end
    end

    assign bus.clk_out      = clk_out_c;
    assign bus.tick         = tick_q;
    assign bus.clk_count    = clk_count;
    assign bus.n_active     = n_active;
    assign bus.load_pending = load_pending;
    assign bus.cfg_err      = cfg_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog
module tb_clk_div_prog;

    logic ref_clk = 1'b0;
    logic reset   = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] pat;

    clk_div_prog_if #(.WIDTH(8)) bus ();

    clk_div_prog #(.WIDTH(8), .DEFAULT_N(8'd4)) dut (
        .ref_clk (ref_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ref_clk);
        #1;
    endtask

    // Samples clk_out once per half cycle, MSB first, starting just after a posedge.
    task automatic sample_halves(input int halves, output logic [31:0] p);
        p = '0;
        for (int k = 0; k < halves; k++) begin
            if (k != 0) begin
                if (k % 2 == 1) @(negedge ref_clk);
                else            @(posedge ref_clk);
                #1;
            end
            p = {p[30:0], bus.clk_out};
        end
    endtask

    task automatic load(input logic [7:0] n, input logic m);
        bus.n_load  = 1'b1;
        bus.n_in    = n;
        bus.mode_in = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en      = 1'b1;
        bus.n_load  = 1'b0;
        bus.n_in    = 8'd0;
        bus.mode_in = 1'b0;
        repeat (2) step();
        check_eq("rst_count",   32'(bus.clk_count), 32'd0);
        check_eq("rst_nact",    32'(bus.n_active), 32'd4);
        check_eq("rst_tick",    32'(bus.tick), 32'd0);
        check_eq("rst_clkout",  32'(bus.clk_out), 32'd0);
        check_eq("rst_pending", 32'(bus.load_pending), 32'd0);
        check_eq("rst_cfgerr",  32'(bus.cfg_err), 32'd0);
        @(negedge ref_clk);
        reset = 1'b0;

        // Default ratio 4, pulse mode
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("n4_count",  32'(bus.clk_count), 32'(3 - (i % 4)));
            check_eq("n4_tick",   32'(bus.tick), 32'(i % 4 == 0));
            check_eq("n4_clkout", 32'(bus.clk_out), 32'(i % 4 == 0));
        end
        check_eq("n4_nact", 32'(bus.n_active), 32'd4);

        // Load 5 / 50% while clk_count==2
        step();
        step();
        check_eq("pre5_count", 32'(bus.clk_count), 32'd2);
        load(8'd5, 1'b1);
        step();
        bus.n_load = 1'b0;
        check_eq("l5_count1",  32'(bus.clk_count), 32'd1);
        check_eq("l5_pend1",   32'(bus.load_pending), 32'd1);
        check_eq("l5_nact1",   32'(bus.n_active), 32'd4);
        step();
        check_eq("l5_count0",  32'(bus.clk_count), 32'd0);
        check_eq("l5_pend0",   32'(bus.load_pending), 32'd1);
        step();
        check_eq("l5_count4",  32'(bus.clk_count), 32'd4);
        check_eq("l5_nact",    32'(bus.n_active), 32'd5);
        check_eq("l5_pendclr", 32'(bus.load_pending), 32'd0);
        check_eq("l5_tick",    32'(bus.tick), 32'd1);
        sample_halves(10, pat);
        check_eq("n5_wave", pat, 32'b1111100000);

        // 50% N=6 via pending, then N=7 loaded on a terminal edge
        step();
        load(8'd6, 1'b1);
        step();
        bus.n_load = 1'b0;
        check_eq("l6_pend", 32'(bus.load_pending), 32'd1);
        repeat (3) step();
        check_eq("l6_count0", 32'(bus.clk_count), 32'd0);
        check_eq("l6_nact5",  32'(bus.n_active), 32'd5);
        step();
        check_eq("l6_count5", 32'(bus.clk_count), 32'd5);
        check_eq("l6_nact",   32'(bus.n_active), 32'd6);
        sample_halves(12, pat);
        check_eq("n6_wave", pat, 32'b111111000000);
        load(8'd7, 1'b1);
        step();
        bus.n_load = 1'b0;
        check_eq("l7_count", 32'(bus.clk_count), 32'd6);
        check_eq("l7_nact",  32'(bus.n_active), 32'd7);
        check_eq("l7_pend",  32'(bus.load_pending), 32'd0);
        sample_halves(14, pat);
        check_eq("n7_wave", pat, 32'b11111110000000);

        // Two loads in one period: last wins; then a rejected zero load
        step();
        load(8'd3, 1'b0);
        step();
        check_eq("l3_pend", 32'(bus.load_pending), 32'd1);
        load(8'd9, 1'b0);
        step();
        bus.n_load = 1'b0;
        check_eq("l9_count", 32'(bus.clk_count), 32'd4);
        repeat (4) step();
        check_eq("l9_nact7", 32'(bus.n_active), 32'd7);
        step();
        check_eq("l9_count8", 32'(bus.clk_count), 32'd8);
        check_eq("l9_nact",   32'(bus.n_active), 32'd9);
        check_eq("l9_clkout", 32'(bus.clk_out), 32'd1);
        load(8'd0, 1'b0);
        step();
        bus.n_load = 1'b0;
        check_eq("z_cfgerr", 32'(bus.cfg_err), 32'd1);
        check_eq("z_nact",   32'(bus.n_active), 32'd9);
        check_eq("z_pend",   32'(bus.load_pending), 32'd0);
        check_eq("z_count",  32'(bus.clk_count), 32'd7);
        step();
        check_eq("z_sticky", 32'(bus.cfg_err), 32'd1);
        load(8'd1, 1'b0);
        step();
        bus.n_load = 1'b0;
        check_eq("l1_cfgclr", 32'(bus.cfg_err), 32'd0);
        check_eq("l1_pend",   32'(bus.load_pending), 32'd1);
        repeat (5) step();
        check_eq("l1_nact9", 32'(bus.n_active), 32'd9);
        step();
        check_eq("l1_nact",  32'(bus.n_active), 32'd1);
        check_eq("l1_count", 32'(bus.clk_count), 32'd0);
        check_eq("l1_tick",  32'(bus.tick), 32'd1);

        // N=1 pass-through and enable gating
        sample_halves(4, pat);
        check_eq("n1_wave", pat, 32'b1010);
        step();
        bus.en = 1'b0;
        @(negedge ref_clk);
        #1;
        check_eq("en0_neg_clkout", 32'(bus.clk_out), 32'd0);
        step();
        check_eq("en0_clkout", 32'(bus.clk_out), 32'd0);
        check_eq("en0_tick",   32'(bus.tick), 32'd0);
        bus.en = 1'b1;
        @(negedge ref_clk);
        #1;
        check_eq("en1_neg_clkout", 32'(bus.clk_out), 32'd0);
        step();
        check_eq("en1_clkout", 32'(bus.clk_out), 32'd1);
        check_eq("en1_tick",   32'(bus.tick), 32'd1);

        // Asynchronous reset mid-period with N=7 50% and a load pending
        load(8'd7, 1'b1);
        step();
        check_eq("r7_nact",   32'(bus.n_active), 32'd7);
        check_eq("r7_clkout", 32'(bus.clk_out), 32'd1);
        load(8'd5, 1'b0);
        step();
        bus.n_load = 1'b0;
        check_eq("r7_pend", 32'(bus.load_pending), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_count",  32'(bus.clk_count), 32'd0);
        check_eq("ar_nact",   32'(bus.n_active), 32'd4);
        check_eq("ar_clkout", 32'(bus.clk_out), 32'd0);
        check_eq("ar_tick",   32'(bus.tick), 32'd0);
        check_eq("ar_pend",   32'(bus.load_pending), 32'd0);
        @(negedge ref_clk);
        reset = 1'b0;
        step();
        check_eq("ar_rel_count",  32'(bus.clk_count), 32'd3);
        check_eq("ar_rel_clkout", 32'(bus.clk_out), 32'd1);
        repeat (4) step();
        check_eq("ar_lost_nact",  32'(bus.n_active), 32'd4);
        check_eq("ar_lost_count", 32'(bus.clk_count), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable integer clock divider with a runtime-loadable ratio, selectable pulse or 50 %-duty output, and glitch-free ratio/mode changes applied only at period boundaries. It sits between the reference clock and downstream blocks that need a slower clock or a once-per-period strobe. It replaces the fixed 3-bit pulse-only divider: the ratio is WIDTH bits wide and the 50 % mode covers odd ratios by using the falling edge.

## Interface
- WIDTH, 8, width of ratio and counter; N range 1..2^WIDTH-1
- DEFAULT_N, 4, active ratio after reset; must be nonzero
- ref_clk  in  1  reference clock; both edges used
- reset  in  1  asynchronous, active-high; clock ref_clk
- en  in  1  divider enable, sampled on posedge
- n_in  in  WIDTH  requested ratio
- mode_in  in  1  requested mode: 0 = pulse, 1 = 50 % duty
- n_load  in  1  one-cycle strobe capturing n_in/mode_in
- clk_out  out  1  divided clock
- tick  out  1  high for the first ref_clk cycle of every period
- clk_count  out  WIDTH  down-counter, N-1 .. 0
- n_active  out  WIDTH  ratio currently in use
- load_pending  out  1  captured request not yet applied
- cfg_err  out  1  sticky: an n_load with n_in==0 was rejected

## Operation
- Reset values: clk_count=0, n_active=DEFAULT_N, active mode=0, clk_out=0, tick=0, load_pending=0, cfg_err=0, negedge flop=0.
- Counter, on posedge with en=1: if clk_count==0 (terminal), load N-1 with the ratio in effect for the new period; otherwise decrement. Period = N ref_clk cycles.
- Load handshake: n_load=1 with n_in!=0 captures {n_in, mode_in}.
  - If clk_count!=0 or en=0, the value goes to a pending register and load_pending=1.
  - If captured on a terminal posedge with en=1, it applies on that same edge and load_pending stays 0.
  - A later load overwrites an earlier pending one; the last one wins.
  - On the next terminal posedge, the pending values are copied to n_active and the active mode, and load_pending clears.
- n_load with n_in==0: the load is ignored, pending state is unchanged, and cfg_err is set. cfg_err clears only on reset or on the next accepted load.
- tick is high while clk_count==n_active-1. It is constant 1 when N=1.
- clk_out, pulse mode: equal to tick. For N=1 it is the pass-through described below.
- clk_out, 50 % mode: H=floor(N/2).
  - p_hi is a posedge flop, high for the first H cycles of the period.
  - n_hi is p_hi re-sampled on negedge.
  - Even N: clk_out=p_hi, giving H cycles high.
  - Odd N≥3: clk_out=p_hi|n_hi, giving H+0.5 cycles high and falling on a negedge.
- N=1, either mode: clk_out = ref_clk AND en_q, where en_q is en registered on negedge. This is the only combinational path to clk_out.
- en=0 sampled on posedge: clk_count is forced to 0, tick=0, and p_hi=0. n_hi clears on the following negedge. clk_out is low by the next negedge with no runt pulse. The first posedge after en returns to 1 is a terminal edge, so a full period starts there.
- Reset mid-period: all state returns to reset values immediately, and the pending request is discarded.

## Timing
- All outputs except the N=1 pass-through are registered.
- clk_out and tick rise clk-to-q after the posedge that loads clk_count=N-1.
- A new ratio takes effect no earlier than the end of the current period, so there is never a truncated or stretched period.
- Latency from n_load to the new ratio: between 0 and N_old-1 posedges.
- In 50 % mode with odd N, the output falls clk-to-q after the negedge in cycle H.
- Period boundaries remain N posedges apart across mode switches. The first period after a switch follows the new mode.
- When en=1 after reset, clk_out first rises at the first posedge after reset deassertion.

## Test plan
- Reset, DEFAULT_N=4, en=1 → clk_count cycles 3,2,1,0; tick and clk_out (pulse mode) are high one cycle in four; n_active=4.
- Load n_in=5 with mode_in=1 while clk_count=2 → load_pending=1 until the terminal edge, then n_active=5. clk_out is high 2.5 cycles, low 2.5 cycles, period 5, and the previous period is unshortened.
- 50 % mode with N=6, then N=7 → high 3 / low 3, then high 3.5 / low 3.5. No glitches at the switch.
- n_load twice in one period (n_in=3, then 9) → only 9 is applied. Then n_load with n_in=0 → cfg_err=1, n_active stays 9. A subsequent valid load clears cfg_err.
- N=1 → clk_out follows ref_clk. Deassert en → clk_out is low within half a cycle. Reassert en → clk_out resumes.
- Assert reset asynchronously mid-period in 50 % mode (N=7) with a load pending → all outputs go to reset values at once, the pending load is lost, and after release n_active=DEFAULT_N.
